// File: rtl/reset_request_generator_pkg.sv
// rtl/reset_request_generator_pkg.sv - shared defaults and helpers for the reset request generator
package reset_request_generator_pkg;

   localparam int RST_DEBOUNCE_CYCLES = 1_000_000;
   localparam int RST_HOLD_CYCLES     = 1024;

   // Counters need at least one bit even when the terminal count is 1.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reset_request_generator_button_debouncer.sv
// rtl/reset_request_generator_button_debouncer.sv - synchronizes and debounces the NES button, flags presses
module button_debouncer
   import reset_request_generator_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = RST_DEBOUNCE_CYCLES
) (
   input  logic clk_i,
   input  logic arstn_i,
   input  logic btn_raw,
   output logic btn_db,
   output logic btn_evt
);

   localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_q1;
   logic          sync_q2;
   logic          btn_db_q;
   logic [CW-1:0] stable_cnt_q;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         sync_q1      <= 1'b0;
         sync_q2      <= 1'b0;
         stable_cnt_q <= '0;
         btn_db       <= 1'b0;
         btn_db_q     <= 1'b0;
         btn_evt      <= 1'b0;
      end else begin
         sync_q1  <= btn_raw;
         sync_q2  <= sync_q1;
         // Any sample that agrees with the accepted level restarts the stability window.
         if (sync_q2 == btn_db) begin
            stable_cnt_q <= '0;
         end else if (stable_cnt_q == CNT_LAST) begin
            btn_db       <= sync_q2;
            stable_cnt_q <= '0;
         end else begin
            stable_cnt_q <= stable_cnt_q + 1'b1;
         end
         btn_db_q <= btn_db;
         btn_evt  <= btn_db & ~btn_db_q;
      end
   end

endmodule

// File: rtl/reset_request_generator.sv
// rtl/reset_request_generator.sv - stretched system and NES reset requests from board reset, button and soft request
module reset_request_generator
   import reset_request_generator_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = RST_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = RST_HOLD_CYCLES
) (
   input  logic       clk_i,
   input  logic       arstn_i,
   input  logic       nes_btn_i,
   input  logic       soft_nes_rst_i,
   output logic       main_arstn_o,
   output logic       nes_arstn_o,
   output logic [7:0] nes_rst_cnt_o
);

   localparam int            HW        = cnt_width(HOLD_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_POR          = 2'd0,
      ST_IDLE         = 2'd1,
      ST_HOLD         = 2'd2,
      ST_WAIT_RELEASE = 2'd3
   } nes_state_t;

   nes_state_t    state_q, state_d;
   logic [HW-1:0] main_cnt_q;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic          main_arstn_q;
   logic          nes_arstn_q;
   logic [7:0]    rst_cnt_q;
   logic          cnt_inc;
   logic          main_rise;
   logic          btn_db;
   logic          btn_evt;

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_button_debouncer (
      .clk_i   (clk_i),
      .arstn_i (arstn_i),
      .btn_raw (nes_btn_i),
      .btn_db  (btn_db),
      .btn_evt (btn_evt)
   );

   assign main_rise = !main_arstn_q && (main_cnt_q == HOLD_LAST);

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         main_cnt_q   <= '0;
         main_arstn_q <= 1'b0;
      end else if (!main_arstn_q) begin
         if (main_rise) begin
            main_arstn_q <= 1'b1;
         end else begin
            main_cnt_q <= main_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      cnt_inc    = 1'b0;
      case (state_q)
         ST_POR: begin
            if (main_rise) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (btn_evt || soft_nes_rst_i) begin
               state_d    = ST_HOLD;
               hold_cnt_d = '0;
               cnt_inc    = 1'b1;
            end
         end
         ST_HOLD: begin
            // A repeated soft request lengthens the current reset rather than issuing a new one.
            if (soft_nes_rst_i) begin
               hold_cnt_d = '0;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d = btn_db ? ST_WAIT_RELEASE : ST_IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         ST_WAIT_RELEASE: begin
            if (!btn_db) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_POR;
      endcase
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q     <= ST_POR;
         hold_cnt_q  <= '0;
         nes_arstn_q <= 1'b0;
         rst_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         nes_arstn_q <= (state_d == ST_IDLE);
         if (cnt_inc && (rst_cnt_q != 8'hFF)) begin
            rst_cnt_q <= rst_cnt_q + 8'd1;
         end
      end
   end

   assign main_arstn_o  = main_arstn_q;
   assign nes_arstn_o   = nes_arstn_q;
   assign nes_rst_cnt_o = rst_cnt_q;

endmodule

// File: tb/tb_reset_request_generator.sv
// tb/tb_reset_request_generator.sv - self-checking bench for reset_request_generator
module tb_reset_request_generator;

   localparam int DEB  = 8;
   localparam int HOLD = 4;

   logic       clk_i          = 1'b0;
   logic       arstn_i        = 1'b0;
   logic       nes_btn_i      = 1'b0;
   logic       soft_nes_rst_i = 1'b0;
   logic       main_arstn_o;
   logic       nes_arstn_o;
   logic [7:0] nes_rst_cnt_o;

   always #5 clk_i = ~clk_i;

   reset_request_generator #(
      .DEBOUNCE_CYCLES (DEB),
      .HOLD_CYCLES     (HOLD)
   ) dut (
      .clk_i          (clk_i),
      .arstn_i        (arstn_i),
      .nes_btn_i      (nes_btn_i),
      .soft_nes_rst_i (soft_nes_rst_i),
      .main_arstn_o   (main_arstn_o),
      .nes_arstn_o    (nes_arstn_o),
      .nes_rst_cnt_o  (nes_rst_cnt_o)
   );

   typedef struct {
      int width;
      int cnt;
   } exp_t;

   typedef struct {
      int g1;
      int g2;
      int exp_width;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[6];
   int   n_tests  = 0;
   int   n_fail   = 0;
   int   inv_viol = 0;
   int   run      = 0;
   int   exp_cnt  = 0;

   task automatic check(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic soft_pulse();
      soft_nes_rst_i = 1'b1;
      tick();
      soft_nes_rst_i = 1'b0;
   endtask

   task automatic wait_nes_high(input string name);
      for (int i = 0; i < 64 && !nes_arstn_o; i++) tick();
      check(name, int'(nes_arstn_o), 1);
   endtask

   // Measures each NES reset pulse and scores it against the oldest expectation.
   always @(negedge clk_i) begin
      if (nes_arstn_o && !main_arstn_o) inv_viol++;
      if (!main_arstn_o) begin
         run = 0;
      end else if (!nes_arstn_o) begin
         run++;
      end else if (run > 0) begin
         exp_t e;
         if (sb_q.size() == 0) begin
            check("unexpected_nes_reset", run, 0);
         end else begin
            e = sb_q.pop_front();
            check("nes_low_width", run, e.width);
            check("nes_rst_cnt", int'(nes_rst_cnt_o), e.cnt);
         end
         run = 0;
      end
   end

   initial begin
      int fall;
      int rise;

      vecs[0] = '{0, 0, 4};
      vecs[1] = '{2, 0, 6};
      vecs[2] = '{2, 2, 8};
      vecs[3] = '{1, 1, 6};
      vecs[4] = '{3, 2, 9};
      vecs[5] = '{1, 3, 8};

      // Power-on reset and release
      repeat (5) tick();
      check("rst_main", int'(main_arstn_o), 0);
      check("rst_nes", int'(nes_arstn_o), 0);
      check("rst_cnt", int'(nes_rst_cnt_o), 0);
      arstn_i = 1'b1;
      tick();
      check("main_edge1", int'(main_arstn_o), 0);
      tick();
      tick();
      check("main_edge3", int'(main_arstn_o), 0);
      check("nes_edge3", int'(nes_arstn_o), 0);
      tick();
      check("main_edge4", int'(main_arstn_o), 1);
      check("nes_edge4", int'(nes_arstn_o), 1);
      check("cnt_after_por", int'(nes_rst_cnt_o), 0);
      tick();

      // Soft requests with optional restarts during HOLD
      foreach (vecs[i]) begin
         exp_cnt++;
         sb_q.push_back('{vecs[i].exp_width, exp_cnt});
         soft_pulse();
         check("soft_nes_low", int'(nes_arstn_o), 0);
         if (vecs[i].g1 > 0) begin
            repeat (vecs[i].g1 - 1) tick();
            soft_pulse();
            if (vecs[i].g2 > 0) begin
               repeat (vecs[i].g2 - 1) tick();
               soft_pulse();
            end
         end
         wait_nes_high("soft_vec_release");
         check("soft_vec_main", int'(main_arstn_o), 1);
         tick();
      end

      // Bouncy button, then a stable press and release
      for (int i = 0; i < 30; i++) begin
         nes_btn_i = ((i / 3) % 2 == 0);
         tick();
      end
      check("bounce_no_reset", int'(nes_arstn_o), 1);
      check("bounce_cnt", int'(nes_rst_cnt_o), exp_cnt);
      exp_cnt++;
      sb_q.push_back('{19, exp_cnt});
      nes_btn_i = 1'b1;
      fall = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (!nes_arstn_o && fall < 0) fall = k;
      end
      check("btn_fall_edge", fall, 12);
      nes_btn_i = 1'b0;
      rise = -1;
      for (int k = 1; k <= 40 && rise < 0; k++) begin
         tick();
         if (nes_arstn_o) rise = k;
      end
      check("btn_rise_edge", rise, 11);
      tick();

      // Button event and soft request on the same cycle
      nes_btn_i = 1'b1;
      repeat (11) tick();
      exp_cnt++;
      sb_q.push_back('{11, exp_cnt});
      soft_pulse();
      nes_btn_i = 1'b0;
      check("both_nes_low", int'(nes_arstn_o), 0);
      wait_nes_high("both_release");
      tick();

      // Board reset during HOLD
      soft_pulse();
      tick();
      tick();
      arstn_i = 1'b0;
      #1;
      check("async_main", int'(main_arstn_o), 0);
      check("async_nes", int'(nes_arstn_o), 0);
      check("async_cnt", int'(nes_rst_cnt_o), 0);
      repeat (3) tick();
      arstn_i = 1'b1;
      tick();
      soft_pulse();
      check("por_nes", int'(nes_arstn_o), 0);
      tick();
      check("rerel_main_edge3", int'(main_arstn_o), 0);
      tick();
      check("rerel_main_edge4", int'(main_arstn_o), 1);
      check("rerel_nes_edge4", int'(nes_arstn_o), 1);
      check("rerel_cnt", int'(nes_rst_cnt_o), 0);
      exp_cnt = 0;
      tick();

      // Count saturation
      for (int n = 0; n < 300; n++) begin
         exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
         sb_q.push_back('{HOLD, exp_cnt});
         soft_pulse();
         wait_nes_high("sat_release");
         tick();
      end
      check("cnt_saturated", int'(nes_rst_cnt_o), 255);

      tick();
      tick();
      check("scoreboard_drained", sb_q.size(), 0);
      check("nes_high_while_main_low", inv_viol, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
